fir_channel_scheduler: RTL and testbench

Time-multiplexes one serial-MAC FIR engine (TAPS-step sweep per output sample) across CHANNELS independent sample streams. Accepts samples per channel over valid/ready, grants the engine round-robin, drives the engine's per-step enable for exactly one full sweep per sample, captures the engine result and returns it tagged with its channel. Sits between the per-channel ADC/decimator front ends and the downstream sample sink; the engine keeps one delay-line bank per channel, selected by `eng_ch`.

---
 rtl/fir_sched_pkg.sv | 16 +
 rtl/fir_channel_scheduler_if.sv | 35 +++
 rtl/fir_rr_arb.sv | 42 ++++
 rtl/fir_channel_scheduler.sv | 101 ++++++++++
 tb/tb_fir_channel_scheduler.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and default sizing for the FIR channel scheduler.
package fir_sched_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_TAPS     = 128;
  localparam int DEF_WIDTH    = 18;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SWEEP,
    DRAIN,
    OUT
  } state_t;

endpackage

// File: rtl/fir_channel_scheduler_if.sv
// Sample-in, engine-control and result-out bundle of the FIR channel scheduler.
// master = scheduler side, slave = front ends / engine / sink side.
interface fir_channel_scheduler_if
  import fir_sched_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CH_W     = $clog2(CHANNELS)
);

  logic [CHANNELS-1:0]       s_valid;
  logic [CHANNELS*WIDTH-1:0] s_data;
  logic [CHANNELS-1:0]       s_ready;
  logic                      eng_clr;
  logic                      eng_en;
  logic [CH_W-1:0]           eng_ch;
  logic signed [WIDTH-1:0]   eng_sample;
  logic signed [WIDTH-1:0]   eng_result;
  logic                      m_valid;
  logic [CH_W-1:0]           m_ch;
  logic signed [WIDTH-1:0]   m_data;
  logic                      m_ready;
  logic                      busy;

  modport master (
    input  s_valid, s_data, eng_result, m_ready,
    output s_ready, eng_clr, eng_en, eng_ch, eng_sample, m_valid, m_ch, m_data, busy
  );

  modport slave (
    output s_valid, s_data, eng_result, m_ready,
    input  s_ready, eng_clr, eng_en, eng_ch, eng_sample, m_valid, m_ch, m_data, busy
  );

endinterface

// File: rtl/fir_rr_arb.sv
// Combinational round-robin arbiter; search starts at ptr.
// FIR_SCHED_PRIO0_EN: request 0 always wins, others stay round-robin.
module fir_rr_arb
  import fir_sched_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [CH_W-1:0]     grant_idx,
  output logic                grant_any
);

  logic [CH_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
`ifdef FIR_SCHED_PRIO0_EN
    if (req[0]) begin
      grant[0]  = 1'b1;
      grant_any = 1'b1;
    end else begin
`else
    begin
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        cand = CH_W'((int'(ptr) + i) % CHANNELS);
        if (!grant_any && req[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one serial-MAC FIR engine across CHANNELS sample streams, one TAPS-step sweep per sample.
// FIR_SCHED_PRIO0_EN gives channel 0 absolute priority over the round-robin.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int TAPS     = DEF_TAPS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  fir_channel_scheduler_if.master bus
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(TAPS);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    step;
  logic [CH_W-1:0]     rr_ptr;
  logic [CHANNELS-1:0] grant;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_any;
  logic                accept;

  fir_rr_arb #(.CHANNELS(CHANNELS)) u_arb (
    .req       (bus.s_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Engine controls decode straight from state so reset kills eng_en without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    state_nxt   = state;
    bus.s_ready = '0;
    bus.eng_clr = 1'b0;
    bus.eng_en  = 1'b0;
    bus.m_valid = 1'b0;
    bus.busy    = 1'b1;
    accept      = 1'b0;
    unique case (state)
      INIT: begin
        bus.eng_clr = 1'b1;
        state_nxt   = IDLE;
      end
      IDLE: begin
        bus.busy = 1'b0;
        if (grant_any) begin
          bus.s_ready = grant;
          accept      = 1'b1;
          state_nxt   = SWEEP;
        end
      end
      SWEEP: begin
        bus.eng_en = 1'b1;
        if (step == CNT_W'(TAPS - 1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = OUT;
      OUT: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step           <= '0;
      rr_ptr         <= '0;
      bus.eng_ch     <= '0;
      bus.eng_sample <= '0;
      bus.m_ch       <= '0;
      bus.m_data     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every capture sees the pre-edge values.
      step <= (state == SWEEP) ? step + 1'b1 : '0;
      if (accept) begin
        bus.eng_sample <= bus.s_data[int'(grant_idx)*WIDTH +: WIDTH];
        bus.eng_ch     <= grant_idx;
`ifdef FIR_SCHED_PRIO0_EN
        if (grant_idx != '0)
`endif
          rr_ptr <= (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == DRAIN) begin
        bus.m_data <= bus.eng_result;
        bus.m_ch   <= bus.eng_ch;
      end
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Randomized bench for fir_channel_scheduler against a transaction-level timing/arbitration model.
// Build with FIR_SCHED_PRIO0_EN defined to check the channel-0 priority variant.
module tb_fir_channel_scheduler;

  localparam int CH   = 4;
  localparam int TAPS = 128;
  localparam int W    = 18;
  localparam int CHW  = $clog2(CH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_channel_scheduler_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  fir_channel_scheduler #(.CHANNELS(CH), .TAPS(TAPS), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Engine stand-in: result folds in sample, bank and number of contiguous steps seen.
  logic signed [W-1:0] eng_res = '0;
  int                  eng_step = 0;
  assign bus.eng_result = eng_res;
  always @(posedge clk) begin
    if (!bus.eng_en) eng_step <= 0;
    else begin
      eng_step <= eng_step + 1;
      eng_res  <= W'(int'(bus.eng_sample) + 7 * int'(bus.eng_ch) + eng_step + 1);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: one transaction in flight, started at acc_cyc.
  bit                  in_flight = 1'b0;
  int                  acc_cyc   = 0;
  int                  exp_ch    = 0;
  logic signed [W-1:0] exp_sample = '0;
  logic signed [W-1:0] exp_result = '0;
  int                  ptr       = 0;
  int                  last_acc  = -1;
  bit                  period_chk = 1'b0;

  logic [CH-1:0] cur_valid = '0;
  logic [W-1:0]  cur_data [CH];
  logic          mrdy = 1'b0;
  int            mode = 0;  // 0: drop valid on accept, 1: keep valid with new data, 2: random
  int            dut_grants[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [CH-1:0] v, input int p);
`ifdef FIR_SCHED_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < CH; i++)
      if (v[CHW'((p + i) % CH)]) return (p + i) % CH;
    return -1;
  endfunction

  task automatic drive();
    bus.s_valid = cur_valid;
    for (int i = 0; i < CH; i++) bus.s_data[i*W +: W] = cur_data[i];
    bus.m_ready = mrdy;
  endtask

  task automatic step();
    logic [CH-1:0] exp_ready;
    bit            exp_mv;
    int            w;
    @(negedge clk);
    if (mode == 2) begin
      for (int i = 0; i < CH; i++) begin
        if (!cur_valid[i] && $urandom_range(7) == 0) begin
          cur_valid[i] = 1'b1;
          cur_data[i]  = W'($urandom);
        end else if (cur_valid[i] && $urandom_range(31) == 0) cur_valid[i] = 1'b0;
      end
      mrdy = ($urandom_range(3) != 0);
    end
    drive();
    #1;
    exp_ready = '0;
    w = -1;
    if (!in_flight) begin
      w = pick(cur_valid, ptr);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    exp_mv = in_flight && (cyc >= acc_cyc + TAPS + 2);
    for (int i = 0; i < CH; i++) if (bus.s_ready[i]) dut_grants.push_back(i);
    check("s_ready", bus.s_ready, exp_ready);
    check("busy", bus.busy, in_flight);
    check("eng_clr", bus.eng_clr, 1'b0);
    check("eng_en", bus.eng_en, in_flight && cyc >= acc_cyc + 1 && cyc <= acc_cyc + TAPS);
    check("m_valid", bus.m_valid, exp_mv);
    if (in_flight && cyc >= acc_cyc + 1) begin
      check("eng_ch", bus.eng_ch, exp_ch);
      check("eng_sample", bus.eng_sample, exp_sample);
    end
    if (exp_mv) begin
      check("m_ch", bus.m_ch, exp_ch);
      check("m_data", bus.m_data, exp_result);
    end
    if (exp_mv && mrdy) in_flight = 1'b0;
    if (w >= 0) begin
      in_flight  = 1'b1;
      acc_cyc    = cyc;
      exp_ch     = w;
      exp_sample = cur_data[w];
      exp_result = W'(int'(exp_sample) + 7 * w + TAPS);
`ifdef FIR_SCHED_PRIO0_EN
      if (w != 0) ptr = (w + 1) % CH;
`else
      ptr = (w + 1) % CH;
`endif
      if (period_chk && last_acc >= 0) check("grant_period", cyc - last_acc, TAPS + 3);
      last_acc = cyc;
      if (mode == 1) cur_data[w] = W'($urandom);
      else cur_valid[w] = 1'b0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic check_reset_values();
    check("rst_eng_clr", bus.eng_clr, 1'b1);
    check("rst_eng_en", bus.eng_en, 1'b0);
    check("rst_s_ready", bus.s_ready, '0);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_ch", bus.m_ch, '0);
    check("rst_m_data", bus.m_data, '0);
    check("rst_eng_ch", bus.eng_ch, '0);
    check("rst_eng_sample", bus.eng_sample, '0);
    check("rst_busy", bus.busy, 1'b1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    cur_valid = '0;
    mrdy      = 1'b0;
    drive();
    #1;
    check_reset_values();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
    check("clr_after_release", bus.eng_clr, 1'b1);
    @(posedge clk);
    in_flight  = 1'b0;
    ptr        = 0;
    last_acc   = -1;
    cyc++;
  endtask

  task automatic idle_out(input int n);
    mode      = 0;
    cur_valid = '0;
    mrdy      = 1'b1;
    repeat (n) step();
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check({tag, "_count"}, dut_grants.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < dut_grants.size(); k++)
      check(tag, dut_grants[k], exp_q[k]);
  endtask

  initial begin
    int  exp_q[$];
    bit  reached;
    for (int i = 0; i < CH; i++) cur_data[i] = '0;
    drive();

    // Reset release and single-channel transaction on channel 2.
    do_reset(3);
    mode         = 0;
    cur_data[2]  = W'(1000);
    cur_valid    = 4'b0100;
    mrdy         = 1'b1;
    dut_grants.delete();
    repeat (TAPS + 8) step();
    exp_q = '{2};
    check_order("single_grant", exp_q);

    // All channels continuously valid with the sink always ready.
    do_reset(2);
    mode = 1;
    for (int i = 0; i < CH; i++) cur_data[i] = W'($urandom);
    cur_valid  = '1;
    mrdy       = 1'b1;
    period_chk = 1'b1;
    dut_grants.delete();
    repeat (5 * (TAPS + 3)) step();
    period_chk = 1'b0;
`ifdef FIR_SCHED_PRIO0_EN
    exp_q = '{0, 0, 0, 0, 0};
`else
    exp_q = '{0, 1, 2, 3, 0};
`endif
    check_order("rr_order", exp_q);
    idle_out(TAPS + 6);

    // Sink back-pressure for 50 cycles while other channels keep requesting.
    cur_data[1] = W'($urandom);
    cur_valid   = 4'b0010;
    mrdy        = 1'b0;
    repeat (TAPS + 3) step();
    mode      = 1;
    cur_valid = '1;
    repeat (50) step();
    mrdy = 1'b1;
    repeat (6) step();
    idle_out(TAPS + 6);

    // Random traffic, random sink readiness, occasional valid withdrawal.
    mode = 2;
    repeat (3000) step();
    idle_out(TAPS + 6);

    // Reset asserted at sweep step 60; the following sweep must be full length.
    cur_data[3] = W'($urandom);
    cur_valid   = 4'b1000;
    reached     = 1'b0;
    for (int k = 0; k < 400 && !reached; k++) begin
      step();
      reached = in_flight && (cyc == acc_cyc + 61);
    end
    check("reach_step60", reached, 1'b1);
    #1;
    check("en_before_rst", bus.eng_en, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("en_async_drop", bus.eng_en, 1'b0);
    check("m_valid_in_rst", bus.m_valid, 1'b0);
    do_reset(2);
    mode        = 0;
    mrdy        = 1'b1;
    cur_data[1] = W'($urandom);
    cur_valid   = 4'b0010;
    repeat (TAPS + 8) step();

    // Channels 0 and 3 permanently valid.
    do_reset(2);
    mode = 1;
    cur_data[0] = W'($urandom);
    cur_data[3] = W'($urandom);
    cur_valid   = 4'b1001;
    mrdy        = 1'b1;
    dut_grants.delete();
    repeat (4 * (TAPS + 3)) step();
`ifdef FIR_SCHED_PRIO0_EN
    exp_q = '{0, 0, 0, 0};
`else
    exp_q = '{0, 3, 0, 3};
`endif
    check_order("ch0_ch3_order", exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
